// File: rtl/line_pkg.sv
// Shared definitions for the line streamer.
//
// Purpose : default geometry of a line and the FSM state encoding.
// Build   : LINE_STREAMER_CKSUM_EN adds the CKSUM state, in which a trailing
//           XOR checksum beat follows the data beats.
package line_pkg;

    localparam int LINE_DATA_W = 128;   // default line width in bits
    localparam int LINE_ADDR_W = 8;     // default line index width in bits

`ifdef LINE_STREAMER_CKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_CKSUM = 2'd2,
        ST_DONE  = 2'd3
    } line_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DONE  = 2'd3
    } line_state_e;
`endif

endpackage : line_pkg

// File: rtl/line_streamer.sv
// line_streamer
//
// Purpose : streams a burst of consecutive lines from an external line memory
//           (combinational read port) onto a valid/ready stream.
//
// Ports   :
//   clk         in   single clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   burst request, sampled only in IDLE
//   base        in   first line index, sampled with start
//   len         in   line count (ADDR_WIDTH+1 bits), sampled with start
//   mem_rindex  out  read index to the line memory
//   mem_rdata   in   read data for mem_rindex, same cycle
//   out_valid   out  stream beat valid
//   out_ready   in   stream sink ready
//   out_data    out  stream beat payload
//   out_last    out  final beat of the burst
//   busy        out  high whenever the FSM is not IDLE
//   done        out  one-cycle pulse when the burst completes
//
// Build   : define LINE_STREAMER_CKSUM_EN to append an XOR checksum beat after
//           the data beats; out_last then marks only the checksum beat.
module line_streamer
    import line_pkg::*;
#(
    parameter int DATA_WIDTH = LINE_DATA_W,
    parameter int ADDR_WIDTH = LINE_ADDR_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] mem_rindex,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int REM_W = ADDR_WIDTH + 1;

    line_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [ADDR_WIDTH-1:0] ptr_q,   ptr_d;
    logic [REM_W-1:0]      rem_q,   rem_d;
    logic                  last_q,  last_d;
`ifdef LINE_STREAMER_CKSUM_EN
    logic [DATA_WIDTH-1:0] cksum_q, cksum_d;
`endif

    logic handshake;

    // The memory index always points one line ahead of the held beat, so the
    // next beat is already on mem_rdata when the current one is accepted.
    // In IDLE it points at base so the first beat can be captured with start.
    assign mem_rindex = (state_q == ST_IDLE) ? base : ptr_q + 1'b1;

`ifdef LINE_STREAMER_CKSUM_EN
    assign out_valid = (state_q == ST_SEND) || (state_q == ST_CKSUM);
`else
    assign out_valid = (state_q == ST_SEND);
`endif
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
`ifdef LINE_STREAMER_CKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
`ifdef LINE_STREAMER_CKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        last_d  = last_q;
`ifdef LINE_STREAMER_CKSUM_EN
        cksum_d = cksum_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef LINE_STREAMER_CKSUM_EN
                    cksum_d = '0;
`endif
                    if (len != '0) begin
                        data_d  = mem_rdata;
                        ptr_d   = base;
                        rem_d   = len;
`ifdef LINE_STREAMER_CKSUM_EN
                        last_d  = 1'b0;
`else
                        last_d  = (len == REM_W'(1));
`endif
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_SEND: begin
                if (handshake) begin
`ifdef LINE_STREAMER_CKSUM_EN
                    // Fold the accepted beat in; the final fold becomes the
                    // checksum beat itself.
                    cksum_d = cksum_q ^ data_q;
`endif
                    if (rem_q != REM_W'(1)) begin
                        data_d = mem_rdata;
                        ptr_d  = ptr_q + 1'b1;
                        rem_d  = rem_q - 1'b1;
`ifndef LINE_STREAMER_CKSUM_EN
                        last_d = (rem_q == REM_W'(2));
`endif
                    end else begin
                        rem_d   = '0;
`ifdef LINE_STREAMER_CKSUM_EN
                        data_d  = cksum_q ^ data_q;
                        last_d  = 1'b1;
                        state_d = ST_CKSUM;
`else
                        last_d  = 1'b0;
                        state_d = ST_DONE;
`endif
                    end
                end
            end

`ifdef LINE_STREAMER_CKSUM_EN
            ST_CKSUM: begin
                if (handshake) begin
                    last_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                // start is deliberately not looked at here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : line_streamer

// File: doc/line_streamer.md
LINE_STREAMER -- requirements
Module: line_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, the line width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, the line index width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port base  input  ADDR_WIDTH  first line index, sampled with start.
REQ-007 SHALL have port len  input  ADDR_WIDTH+1  line count, sampled with start.
REQ-008 SHALL have port mem_rindex  output  ADDR_WIDTH  read index to the line memory.
REQ-009 SHALL have port mem_rdata  input  DATA_WIDTH  combinational read data for mem_rindex.
REQ-010 SHALL have port out_valid  output  1  stream beat valid.
REQ-011 SHALL have port out_ready  input  1  stream sink ready.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  stream beat payload.
REQ-013 SHALL have port out_last  output  1  final beat of burst.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement states IDLE, SEND, CKSUM (macro builds only), DONE.
REQ-017 SHALL drive mem_rindex = base in IDLE and mem_rindex = (ptr+1) mod 2^ADDR_WIDTH otherwise, ptr being the index of the beat currently held.
REQ-018 SHALL, on start=1 in IDLE with len!=0, register out_data<=mem_rdata, ptr<=base, remaining<=len, enter SEND; first out_valid in the next cycle.
REQ-019 SHALL, on start=1 in IDLE with len==0, enter DONE directly, emitting no beats.
REQ-020 SHALL hold out_valid=1 in SEND with out_data, out_last stable until out_valid&&out_ready.
REQ-021 SHALL, on a SEND handshake with remaining>1, load out_data<=mem_rdata, ptr<=ptr+1, remaining<=remaining-1, staying in SEND (one beat per cycle under constant ready).
REQ-022 SHALL, on a SEND handshake with remaining==1, leave SEND (to CKSUM or DONE per REQ-032/033).
REQ-023 SHALL wrap line indices modulo 2^ADDR_WIDTH; len above 2^ADDR_WIDTH re-reads indices from base.
REQ-024 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-025 SHALL ignore start whenever state is not IDLE, including DONE.
REQ-026 SHALL keep out_valid=0 outside SEND/CKSUM; out_data value then don't-care.

Reset
REQ-027 SHALL on resetn=0 immediately force state IDLE, out_valid=0, out_last=0, done=0, busy=0, out_data=0, ptr=0, remaining=0, checksum=0.
REQ-028 SHALL abandon any burst in progress on reset, no done pulse, no partial-beat replay after release.
REQ-029 SHALL accept start in the first clock edge after resetn rises.

Configuration
REQ-030 SHALL support macro LINE_STREAMER_CKSUM_EN.
REQ-031 SHALL, with macro defined, XOR-accumulate every data beat into a DATA_WIDTH checksum register, cleared on start.
REQ-032 SHALL, with macro defined, after the last data handshake enter CKSUM, presenting out_data=checksum, out_last=1; on handshake go to DONE; data beats then have out_last=0; len==0 emits no checksum.
REQ-033 SHALL, without macro, assert out_last on the final data beat, go SEND->DONE, contain no checksum logic.

Structure
REQ-034 SHALL place state encoding enum and default widths in shared package line_pkg.
REQ-035 SHALL be a single module; no sub-module required (memory is external).

Verification
REQ-036 SHALL test: mem[i]=i, base=4, len=3, out_ready=1 -> beats 4,5,6 on consecutive cycles, out_last on 6, done one cycle after.
REQ-037 SHALL test: base=254, len=4 (ADDR_WIDTH=8) -> beats 254,255,0,1.
REQ-038 SHALL test: out_ready toggled 1,0,0,1,... -> no beat lost or duplicated, out_data stable while stalled.
REQ-039 SHALL test: len=0 -> no out_valid, done pulse one cycle after start; start while busy -> ignored.
REQ-040 SHALL test: resetn low mid-burst after 2 beats -> out_valid drops at once, new burst base=0,len=1 afterwards yields beat 0 only.
REQ-041 SHALL test with LINE_STREAMER_CKSUM_EN: lines 0x1,0x2,0x4 -> 4th beat 0x7 with out_last, data beats out_last=0.
